// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock, with the key schedule
// expanded on the fly from a sliding window of the most recent Nk key words.
module aes_cipher_iter #(
    parameter int unsigned MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:127]          in,
    input  logic [0:MAX_NK*32-1]  key,
    input  logic [1:0]            key_len,
    output logic [0:127]          out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);
    localparam int unsigned KW = MAX_NK * 32;

    // Forward S-box, byte 0 in the leftmost position.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [31:0]  w_q [0:7];
    logic [31:0]  w_d [0:7];
    logic [1:0]   klen_q, klen_d;
    logic [2:0]   phase_q, phase_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         err_d, in_ready_d, out_valid_d;

    logic [0:255] key_pad;
    logic [3:0]   nk, nr, nk_in;
    logic         bad_len, last;
    logic [31:0]  ext [0:11];
    logic [7:0]   rcon_nx;
    logic [2:0]   phase_nx;
    logic [127:0] st_rnd;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    assign out = st_q;

    // Zero-extend the key port to the full 8-word window.
    always_comb begin
        key_pad = '0;
        key_pad[0:KW-1] = key;
    end

    // Key size decode for the offered block and for the latched block.
    always_comb begin
        case (key_len)
            2'd0:    nk_in = 4'd4;
            2'd1:    nk_in = 4'd6;
            default: nk_in = 4'd8;
        endcase
        bad_len = (key_len == 2'd3) || (32'(nk_in) > MAX_NK);
        case (klen_q)
            2'd0:    nk = 4'd4;
            2'd1:    nk = 4'd6;
            default: nk = 4'd8;
        endcase
        nr   = nk + 4'd6;
        last = (rnd_q == nr);
    end

    // Next four schedule words; ext is the window followed by the new words,
    // so ext[4..7] is always the current round key.
    always_comb begin
        logic [31:0] prev, tmp;
        logic [31:0] nw [0:3];
        logic [3:0]  pos;
        logic [7:0]  rc;
        rc   = rcon_q;
        prev = w_q[3'(nk - 4'd1)];
        for (int k = 0; k < 4; k++) begin
            pos = 4'(phase_q) + 4'(k);
            if (pos >= nk) pos = pos - nk;
            tmp = prev;
            if (pos == 4'd0) begin
                tmp = sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h0};
                rc  = xtime(rc);
            end else if (nk == 4'd8 && pos == 4'd4) begin
                tmp = sub_word(prev);
            end
            nw[k] = w_q[k] ^ tmp;
            prev  = nw[k];
        end
        rcon_nx = rc;
        pos = 4'(phase_q) + 4'd4;
        if (pos >= nk) pos = pos - nk;
        phase_nx = 3'(pos);
        for (int i = 0; i < 8; i++) ext[i] = w_q[i];
        for (int i = 8; i < 12; i++) ext[i] = '0;
        for (int k = 0; k < 4; k++) ext[nk + 4'(k)] = nw[k];
    end

    // One cipher round; MixColumns is bypassed on the final round.
    always_comb begin
        logic [7:0]  sb [0:15];
        logic [7:0]  sr [0:15];
        logic [7:0]  a0, a1, a2, a3;
        logic [31:0] col;
        st_rnd = '0;
        for (int n = 0; n < 16; n++) sb[n] = sbox(st_q[127 - 8*n -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c + 1];
            a2 = sr[4*c + 2];
            a3 = sr[4*c + 3];
            if (last) begin
                col = {a0, a1, a2, a3};
            end else begin
                col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
            st_rnd[127 - 32*c -: 32] = col ^ ext[4 + c];
        end
    end

    // FSM next state and next values of all registered state and outputs.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        klen_d  = klen_q;
        phase_d = phase_q;
        rcon_d  = rcon_q;
        rnd_d   = rnd_q;
        err_d   = err;
        for (int i = 0; i < 8; i++) w_d[i] = w_q[i];
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    klen_d  = key_len;
                    rnd_d   = 4'd1;
                    phase_d = 3'd0;
                    rcon_d  = 8'h01;
                    for (int i = 0; i < 8; i++) w_d[i] = key_pad[32*i +: 32];
                    if (bad_len) begin
                        state_d = DONE;
                        st_d    = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        st_d    = in ^ key_pad[0:127];
                        err_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                st_d    = st_rnd;
                phase_d = phase_nx;
                rcon_d  = rcon_nx;
                rnd_d   = rnd_q + 4'd1;
                for (int i = 0; i < 8; i++) w_d[i] = ext[i + 4];
                if (last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            st_q      <= '0;
            klen_q    <= '0;
            phase_q   <= '0;
            rcon_q    <= '0;
            rnd_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < 8; i++) w_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            klen_q    <= klen_d;
            phase_q   <= phase_d;
            rcon_q    <= rcon_d;
            rnd_q     <= rnd_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            err       <= err_d;
            for (int i = 0; i < 8; i++) w_q[i] <= w_d[i];
        end
    end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: known-answer vectors, backpressure,
// invalid key sizes, mid-block reset, input isolation and random blocks.
module tb_aes_cipher_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, in_valid, in_ready, out_valid, out_ready, err;
    logic [0:127]   in, out;
    logic [0:255]   key;
    logic [1:0]     key_len;
    logic           in_valid6, in_ready6, out_valid6, out_ready6, err6;
    logic [0:127]   in6, out6;
    logic [0:191]   key6;
    logic [1:0]     key_len6;

    aes_cipher_iter #(.MAX_NK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in(in), .key(key), .key_len(key_len), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    aes_cipher_iter #(.MAX_NK(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
        .in(in6), .key(key6), .key_len(key_len6), .out(out6), .out_valid(out_valid6),
        .out_ready(out_ready6), .err(err6)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sbox_t [256];
    bit         sel = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_t[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    // Textbook AES encryption with a fully expanded key schedule.
    function automatic logic [127:0] aes_ref(input logic [0:127] pt, input logic [0:255] k,
                                             input int nk);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rcon_t [10];
        logic [31:0]  tmp;
        logic [127:0] res;
        int           nr;
        rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0)
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]],
                       sbox_t[tmp[31:24]]} ^ {rcon_t[i/nk - 1], 24'h0};
            else if (nk > 6 && i % nk == 4)
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]],
                       sbox_t[tmp[7:0]]};
            w[i] = w[i-nk] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ w[n/4][31 - 8*(n%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    t[4*c + i] = sbox_t[s[4*((c + i) % 4) + i]];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) begin
                    if (r < nr)
                        s[4*c + i] = gmul(8'h02, t[4*c + i]) ^ gmul(8'h03, t[4*c + (i+1)%4])
                                     ^ t[4*c + (i+2)%4] ^ t[4*c + (i+3)%4];
                    else
                        s[4*c + i] = t[4*c + i];
                end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31 - 8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[127 - 8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic f_rdy();
        return sel ? in_ready6 : in_ready;
    endfunction
    function automatic logic f_vld();
        return sel ? out_valid6 : out_valid;
    endfunction
    function automatic logic f_err();
        return sel ? err6 : err;
    endfunction
    function automatic logic [127:0] f_out();
        return sel ? out6 : out;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer on the selected DUT, with optional backpressure and
    // scrambling of the inputs while the block is in flight.
    task automatic run(input string tag, input logic [0:127] pt, input logic [0:255] k,
                       input logic [1:0] kl, input logic [127:0] exp, input int hold,
                       input bit scr);
        int           nk, lat, wc;
        bit           bad, stable;
        logic [127:0] exp_o;
        nk    = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        bad   = (kl == 2'd3) || (nk > (sel ? 6 : 8));
        exp_o = bad ? 128'h0 : exp;
        wc = 0;
        while (!f_rdy() && wc < 50) begin tick(); wc++; end
        check({tag, " ready"}, 128'(f_rdy()), 128'(1));
        if (sel) begin
            in6 = pt; key6 = k[0:191]; key_len6 = kl; in_valid6 = 1'b1;
        end else begin
            in = pt; key = k; key_len = kl; in_valid = 1'b1;
        end
        tick();
        in_valid = 1'b0;
        in_valid6 = 1'b0;
        lat = 0;
        while (!f_vld() && lat < 40) begin
            if (scr && !sel) begin
                in = rnd128(); key = {rnd128(), rnd128()};
                key_len = 2'($urandom_range(0, 3)); in_valid = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 128'(lat), bad ? 128'(0) : 128'(nk + 6));
        check({tag, " out"}, f_out(), exp_o);
        check({tag, " err"}, 128'(f_err()), 128'(bad));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (f_out() !== exp_o || f_vld() !== 1'b1 || f_rdy() !== 1'b0) stable = 1'b0;
        end
        check({tag, " hold"}, 128'(stable), 128'(1));
        if (sel) out_ready6 = 1'b1; else out_ready = 1'b1;
        tick();
        check({tag, " consumed"}, 128'(f_vld()), 128'(0));
        check({tag, " ready again"}, 128'(f_rdy()), 128'(1));
        out_ready = 1'b0;
        out_ready6 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:255] kat_k, junk, kk;
        logic [0:127] pt, pt2;
        logic [127:0] c128, c192, c256, cbp;
        bit           no_res;
        kat_k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pt    = 128'h00112233445566778899aabbccddeeff;
        pt2   = 128'h000102030405060708090a0b0c0d0e0f;
        c128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        c192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        c256  = 128'h8ea2b7ca516745bfeafc49904b496089;
        cbp   = 128'h0a940bb5416ef045f1c39458c653ea5a;
        junk  = {rnd128(), rnd128()};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in = '0; key = '0; key_len = '0;
        in_valid6 = 1'b0; out_ready6 = 1'b0; in6 = '0; key6 = '0; key_len6 = '0;
        build_sbox();

        check("ref aes128", aes_ref(pt, {kat_k[0:127], junk[0:127]}, 4), c128);
        check("ref aes192", aes_ref(pt, {kat_k[0:191], junk[0:63]}, 6), c192);
        check("ref aes256", aes_ref(pt, kat_k, 8), c256);

        repeat (3) tick();
        check("rst in_ready", 128'(in_ready), 128'(0));
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst err", 128'(err), 128'(0));
        check("rst out", out, 128'h0);
        check("rst in_ready6", 128'(in_ready6), 128'(0));
        rst_n = 1'b1;
        tick();
        check("post-rst in_ready", 128'(in_ready), 128'(1));
        check("post-rst in_ready6", 128'(in_ready6), 128'(1));

        sel = 1'b0;
        run("kat128", pt, {kat_k[0:127], junk[0:127]}, 2'd0, c128, 0, 1'b0);
        run("kat192", pt, {kat_k[0:191], junk[0:63]}, 2'd1, c192, 0, 1'b0);
        run("kat256", pt, kat_k, 2'd2, c256, 0, 1'b0);
        run("backpressure", pt2, {pt2, junk[0:127]}, 2'd0, cbp, 20, 1'b0);
        run("klen3", pt, kat_k, 2'd3, 128'h0, 2, 1'b0);

        sel = 1'b1;
        run("nk6 klen2", pt, kat_k, 2'd2, 128'h0, 1, 1'b0);
        run("nk6 kat192", pt, {kat_k[0:191], junk[0:63]}, 2'd1, c192, 0, 1'b0);
        run("nk6 kat128", pt, {kat_k[0:127], junk[0:127]}, 2'd0, c128, 0, 1'b0);
        run("nk6 klen3", pt, kat_k, 2'd3, 128'h0, 0, 1'b0);

        sel = 1'b0;
        in = pt; key = kat_k; key_len = 2'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("midrst busy", 128'(out_valid), 128'(0));
        rst_n = 1'b0;
        tick();
        check("midrst in_ready", 128'(in_ready), 128'(0));
        check("midrst out_valid", 128'(out_valid), 128'(0));
        check("midrst out", out, 128'h0);
        rst_n = 1'b1;
        tick();
        check("midrst ready back", 128'(in_ready), 128'(1));
        no_res = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0) no_res = 1'b0;
        end
        check("midrst no result", 128'(no_res), 128'(1));
        run("after rst kat128", pt, {kat_k[0:127], junk[0:127]}, 2'd0, c128, 0, 1'b0);

        run("iso kat256", pt, kat_k, 2'd2, c256, 0, 1'b1);
        run("iso kat128", pt, {kat_k[0:127], junk[0:127]}, 2'd0, c128, 3, 1'b1);

        for (int it = 0; it < 24; it++) begin
            logic [1:0]   kl;
            logic [127:0] exp;
            int           nk;
            kl  = 2'($urandom_range(0, 3));
            pt  = rnd128();
            kk  = {rnd128(), rnd128()};
            nk  = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
            exp = (kl == 2'd3) ? 128'h0 : aes_ref(pt, kk, nk);
            run($sformatf("rnd%0d", it), pt, kk, kl, exp, $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 Parameter MAX_NK, default 8, SHALL set the largest supported key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 Port in_valid  input  1  SHALL flag that a block and key are offered.
REQ-005 Port in_ready  output  1  SHALL flag that the core can accept a block.
REQ-006 Port in  input  128  SHALL carry the plaintext, indexed [0:127], where bit 0 is the MSB of byte 0.
REQ-007 Port key  input  MAX_NK*32  SHALL carry the cipher key, indexed [0:MAX_NK*32-1]; an Nk-word key occupies key[0:Nk*32-1] and the remaining bits are ignored.
REQ-008 Port key_len  input  2  SHALL select the key size: 0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=reserved.
REQ-009 Port out  output  128  SHALL carry the ciphertext, indexed [0:127].
REQ-010 Port out_valid  output  1  SHALL flag that out and err are valid.
REQ-011 Port out_ready  input  1  SHALL flag that the consumer takes the result.
REQ-012 Port err  output  1  SHALL flag an unsupported key_len for the current result.

Function
REQ-013 The core SHALL implement FIPS-197 encryption iteratively, one round per clock, with on-the-fly key expansion producing 4 round-key words per cycle from an Nk-word sliding window.
REQ-014 The FSM SHALL have three states:
- IDLE: in_ready=1.
- BUSY: rounds in progress.
- DONE: out_valid=1.
REQ-015 An accept SHALL occur at an edge with in_valid=1 and in_ready=1; in, key and key_len SHALL be latched at that edge, and later changes to them SHALL have no effect on the in-flight block.
REQ-016 At the accept edge, the state register SHALL load in XOR key[0:127], the round counter SHALL load 1, and the FSM SHALL go IDLE->BUSY.
REQ-017 In BUSY, each edge SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey; MixColumns SHALL be omitted on round Nr.
REQ-018 At the edge completing round Nr, the FSM SHALL go BUSY->DONE; out_valid SHALL rise exactly Nr edges after the accept edge (10, 12 or 14 cycles).
REQ-019 In DONE, out and err SHALL stay stable until an edge with out_ready=1; at that edge the FSM SHALL go DONE->IDLE and out_valid SHALL fall.
REQ-020 in_ready SHALL be 0 in BUSY and DONE, so no accept can occur in the cycle a result is consumed; throughput SHALL be one block per Nr+2 cycles when out_ready is held at 1.
REQ-021 Unsupported key lengths SHALL be rejected without running rounds: when key_len=3, or when key_len selects Nk>MAX_NK, the accept SHALL go IDLE->DONE in one edge with out=0 and err=1.
REQ-022 err SHALL be 0 for every supported key length.
REQ-023 Rcon SHALL advance on every word i with i mod Nk==0.
REQ-024 For Nk=8, SubWord without RotWord and without Rcon SHALL be applied on every word i with i mod 8==4.
REQ-025 All arithmetic SHALL be GF(2^8) with polynomial 0x11B; the S-box SHALL be an internal combinational table.
REQ-026 A block SHALL never be dropped or duplicated: each accept SHALL produce exactly one out_valid/out_ready transfer.

Reset
REQ-027 While rst_n=0 at an edge, the FSM SHALL go to IDLE, and in_ready=0, out_valid=0, err=0, out=0 and the round counter=0.
REQ-028 At the first edge with rst_n=1, the FSM SHALL still be IDLE and in_ready SHALL rise to 1.
REQ-029 Reset asserted in BUSY or DONE SHALL discard the in-flight block, and no out_valid SHALL follow for it.

Verification
REQ-030 AES-128 vector: in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, key_len=0 -> out=69c4e0d86a7b0430d8cdb78070b4c55a, err=0, out_valid 10 cycles after accept.
REQ-031 AES-192 and AES-256 vectors: in=00112233445566778899aabbccddeeff.
- key=000102...17, key_len=1 -> out=dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
- key=000102...1f, key_len=2 -> out=8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-032 Backpressure: in=000102030405060708090a0b0c0d0e0f, key=000102030405060708090a0b0c0d0e0f, key_len=0, out_ready held 0 for 20 cycles -> out=0a940bb5416ef045f1c39458c653ea5a held stable and in_ready=0 throughout; result consumed on the first edge with out_ready=1.
REQ-033 Invalid mode: key_len=3, and separately key_len=2 with MAX_NK=6 -> out_valid one cycle after accept, err=1, out=0.
REQ-034 Reset mid-operation: rst_n=0 for 1 cycle, 5 cycles into an AES-256 block -> no result for that block; in_ready=1 one cycle after rst_n rises; a new AES-128 block then gives the REQ-030 result.
REQ-035 Input isolation: change in and key every cycle while BUSY -> result matches the values latched at accept.
